// File: rtl/pdm_cic_ctrl.sv
// PDM microphone front end for the shared multi-channel CIC decimator: PDM clock, dual-edge
// sampling, strict channel-order feed and a tagged PCM output FIFO. Define PDM_CIC_CTRL_DROP_CNT_EN for drop_cnt_o.
module pdm_cic_ctrl #(
  parameter int DIV_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             cfg_en_i,
  input  logic [1:0]       cfg_ch_num_i,
  input  logic [DIV_W-1:0] cfg_clk_div_i,
  output logic             pdm_clk_o,
  input  logic [1:0]       pdm_data_i,
  output logic             cic_en_o,
  output logic [1:0]       cic_ch_num_o,
  output logic             cic_data_o,
  output logic             cic_valid_o,
  input  logic [15:0]      cic_pcm_i,
  input  logic             cic_pcm_valid_i,
  output logic [15:0]      pcm_data_o,
  output logic [1:0]       pcm_ch_o,
  output logic             pcm_valid_o,
  input  logic             pcm_ready_i,
  output logic             overflow_o
`ifdef PDM_CIC_CTRL_DROP_CNT_EN
  ,
  output logic [7:0]       drop_cnt_o
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_FEED = 2'd2
  } state_t;

  logic             en_d_r;
  logic [1:0]       ch_num_r;
  logic [DIV_W-1:0] div_r;
  state_t           state_r;
  logic [1:0]       idx_r;
  logic [DIV_W-1:0] cnt_r;
  logic             pdm_clk_r;
  logic             tog_hi_d_r;
  logic             tog_lo_d_r;
  logic [3:0]       slot_r;
  logic             cic_valid_r;
  logic             cic_data_r;
  logic [1:0]       strobe_ch_r;

  logic [17:0]      mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             pcm_valid_r;
  logic             overflow_r;

  logic             en_rise_s;
  logic             toggle_s;
  logic             frame_lost_s;
  logic             push_s;
  logic             pop_s;
  logic             full_s;
  logic             drop_s;
  logic             wr_en_s;
  logic [CNT_W-1:0] next_count_s;

  // Event decode for divider, frame hand-off and FIFO traffic
  always_comb begin
    en_rise_s    = cfg_en_i & ~en_d_r;
    toggle_s     = (state_r != ST_IDLE) && (cnt_r == div_r);
    frame_lost_s = (state_r == ST_FEED) && tog_lo_d_r;
    push_s       = cic_valid_r && cic_pcm_valid_i;
    pop_s        = pcm_valid_r && pcm_ready_i;
    full_s       = (count_r == CNT_W'(FIFO_DEPTH));
    drop_s       = push_s && full_s && !pop_s;
    wr_en_s      = push_s && !drop_s;
    if (wr_en_s && !pop_s) begin
      next_count_s = count_r + CNT_W'(1);
    end else if (!wr_en_s && pop_s) begin
      next_count_s = count_r - CNT_W'(1);
    end else begin
      next_count_s = count_r;
    end
  end

  // Enable edge detect; session configuration is frozen at the rising edge
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      en_d_r   <= 1'b0;
      ch_num_r <= 2'd0;
      div_r    <= '0;
    end else begin
      en_d_r <= cfg_en_i;
      if (en_rise_s) begin
        ch_num_r <= cfg_ch_num_i;
        div_r    <= cfg_clk_div_i;
      end
    end
  end

  // PDM clock divider; the toggle events are delayed one cycle so the
  // microphone has a full system cycle to drive the new phase's bit
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_r      <= '0;
      pdm_clk_r  <= 1'b0;
      tog_hi_d_r <= 1'b0;
      tog_lo_d_r <= 1'b0;
    end else if (!cfg_en_i || state_r == ST_IDLE) begin
      cnt_r      <= '0;
      pdm_clk_r  <= 1'b0;
      tog_hi_d_r <= 1'b0;
      tog_lo_d_r <= 1'b0;
    end else begin
      tog_hi_d_r <= toggle_s && !pdm_clk_r;
      tog_lo_d_r <= toggle_s && pdm_clk_r;
      if (toggle_s) begin
        cnt_r     <= '0;
        pdm_clk_r <= ~pdm_clk_r;
      end else begin
        cnt_r <= cnt_r + DIV_W'(1);
      end
    end
  end

  // Slot capture: high phase feeds even slots, low phase feeds odd slots
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      slot_r <= 4'd0;
    end else begin
      if (tog_hi_d_r) begin
        slot_r[0] <= pdm_data_i[0];
        slot_r[2] <= pdm_data_i[1];
      end
      if (tog_lo_d_r) begin
        slot_r[1] <= pdm_data_i[0];
        slot_r[3] <= pdm_data_i[1];
      end
    end
  end

  // Sequencer: one strobe per active channel after each completed frame
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r     <= ST_IDLE;
      idx_r       <= 2'd0;
      cic_valid_r <= 1'b0;
      cic_data_r  <= 1'b0;
      strobe_ch_r <= 2'd0;
    end else if (!cfg_en_i) begin
      state_r     <= ST_IDLE;
      idx_r       <= 2'd0;
      cic_valid_r <= 1'b0;
      cic_data_r  <= 1'b0;
      strobe_ch_r <= 2'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cic_valid_r <= 1'b0;
          cic_data_r  <= 1'b0;
          idx_r       <= 2'd0;
          if (en_d_r) begin
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          cic_valid_r <= 1'b0;
          cic_data_r  <= 1'b0;
          idx_r       <= 2'd0;
          if (tog_lo_d_r) begin
            state_r <= ST_FEED;
          end
        end
        ST_FEED: begin
          cic_valid_r <= 1'b1;
          cic_data_r  <= slot_r[idx_r];
          strobe_ch_r <= idx_r;
          if (idx_r == ch_num_r) begin
            state_r <= ST_WAIT;
            idx_r   <= 2'd0;
          end else begin
            idx_r <= idx_r + 2'd1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          idx_r       <= 2'd0;
          cic_valid_r <= 1'b0;
          cic_data_r  <= 1'b0;
        end
      endcase
    end
  end

  // PCM FIFO: first-word-fall-through, no empty bypass, flushed while disabled
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 18'd0;
      end
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      pcm_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else if (!cfg_en_i) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      pcm_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= {strobe_ch_r, cic_pcm_i};
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r     <= next_count_s;
      pcm_valid_r <= (next_count_s != CNT_W'(0));
      overflow_r  <= overflow_r | drop_s | frame_lost_s;
    end
  end

`ifdef PDM_CIC_CTRL_DROP_CNT_EN
  logic [7:0] drop_cnt_r;
  logic [8:0] drop_sum_s;
  logic [7:0] drop_next_s;

  // Saturating sum; a dropped word and a lost frame can coincide
  always_comb begin
    drop_sum_s = {1'b0, drop_cnt_r} + {8'd0, drop_s} + {8'd0, frame_lost_s};
    if (drop_sum_s > 9'd255) begin
      drop_next_s = 8'd255;
    end else begin
      drop_next_s = drop_sum_s[7:0];
    end
  end

  // Drop counter shares the clear condition of the overflow flag
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      drop_cnt_r <= 8'd0;
    end else if (!cfg_en_i) begin
      drop_cnt_r <= 8'd0;
    end else begin
      drop_cnt_r <= drop_next_s;
    end
  end

  assign drop_cnt_o = drop_cnt_r;
`endif

  assign pdm_clk_o              = pdm_clk_r;
  assign cic_en_o               = en_d_r;
  assign cic_ch_num_o           = ch_num_r;
  assign cic_data_o             = cic_data_r;
  assign cic_valid_o            = cic_valid_r;
  assign {pcm_ch_o, pcm_data_o} = mem_r[rd_ptr_r];
  assign pcm_valid_o            = pcm_valid_r;
  assign overflow_o             = overflow_r;

endmodule

// File: tb/tb_pdm_cic_ctrl.sv
// Directed bench for pdm_cic_ctrl: PDM timing, channel feed order, PCM FIFO and disable handling.
module tb_pdm_cic_ctrl;

  localparam int DIV_W      = 8;
  localparam int FIFO_DEPTH = 4;

  logic             clk_i = 1'b0;
  logic             rstn_i;
  logic             cfg_en_i;
  logic [1:0]       cfg_ch_num_i;
  logic [DIV_W-1:0] cfg_clk_div_i;
  logic             pdm_clk_o;
  logic [1:0]       pdm_data_i;
  logic             cic_en_o;
  logic [1:0]       cic_ch_num_o;
  logic             cic_data_o;
  logic             cic_valid_o;
  logic [15:0]      cic_pcm_i;
  logic             cic_pcm_valid_i;
  logic [15:0]      pcm_data_o;
  logic [1:0]       pcm_ch_o;
  logic             pcm_valid_o;
  logic             pcm_ready_i;
  logic             overflow_o;
`ifdef PDM_CIC_CTRL_DROP_CNT_EN
  logic [7:0]       drop_cnt_o;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [1:0]  hi_bits;
  logic [1:0]  lo_bits;
  logic [15:0] pcm_tab [8];
  int          pcm_idx;
  int          model_left;

  pdm_cic_ctrl #(.DIV_W(DIV_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_i           (clk_i),
    .rstn_i          (rstn_i),
    .cfg_en_i        (cfg_en_i),
    .cfg_ch_num_i    (cfg_ch_num_i),
    .cfg_clk_div_i   (cfg_clk_div_i),
    .pdm_clk_o       (pdm_clk_o),
    .pdm_data_i      (pdm_data_i),
    .cic_en_o        (cic_en_o),
    .cic_ch_num_o    (cic_ch_num_o),
    .cic_data_o      (cic_data_o),
    .cic_valid_o     (cic_valid_o),
    .cic_pcm_i       (cic_pcm_i),
    .cic_pcm_valid_i (cic_pcm_valid_i),
    .pcm_data_o      (pcm_data_o),
    .pcm_ch_o        (pcm_ch_o),
    .pcm_valid_o     (pcm_valid_o),
    .pcm_ready_i     (pcm_ready_i),
    .overflow_o      (overflow_o)
`ifdef PDM_CIC_CTRL_DROP_CNT_EN
    ,
    .drop_cnt_o      (drop_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Microphone model: one bit pattern for the high phase, another for the low phase
  always @(negedge clk_i) pdm_data_i = pdm_clk_o ? hi_bits : lo_bits;

  // CIC model: answers the next model_left strobes with words from pcm_tab
  always @(negedge clk_i) begin
    if (cic_valid_o && model_left > 0) begin
      cic_pcm_valid_i = 1'b1;
      cic_pcm_i       = pcm_tab[pcm_idx];
      pcm_idx         = pcm_idx + 1;
      model_left      = model_left - 1;
    end else begin
      cic_pcm_valid_i = 1'b0;
      cic_pcm_i       = 16'h0000;
    end
  end

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic wait_pdm_edge(input logic lvl, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (pdm_clk_o !== lvl) break;
      tick();
    end
    for (int i = 0; i < 64; i++) begin
      tick();
      if (pdm_clk_o === lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_strobe(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (cic_valid_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_pcm(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (pcm_valid_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic start_session(input logic [1:0] ch, input logic [7:0] div, input int words);
    cfg_en_i = 1'b0;
    tick();
    tick();
    pcm_idx       = 0;
    model_left    = words;
    cfg_ch_num_i  = ch;
    cfg_clk_div_i = div;
    cfg_en_i      = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({pdm_clk_o, cic_en_o, cic_ch_num_o, cic_data_o, cic_valid_o} !== 6'd0) begin
      n_err++;
      $display("FAIL reset_ctl: got %b want 000000",
               {pdm_clk_o, cic_en_o, cic_ch_num_o, cic_data_o, cic_valid_o});
    end
    n_cmp++;
    if ({pcm_data_o, pcm_ch_o, pcm_valid_o, overflow_o} !== 20'd0) begin
      n_err++;
      $display("FAIL reset_fifo: got %h want 0", {pcm_data_o, pcm_ch_o, pcm_valid_o, overflow_o});
    end
    rstn_i = 1'b1;
    tick();
  endtask

  task automatic test_divider_sampling();
    bit ok;
    int n;
    int hi_len;
    hi_bits = 2'b01;
    lo_bits = 2'b00;
    start_session(2'd1, 8'd3, 0);
    n_cmp++;
    if (pdm_clk_o !== 1'b0) begin
      n_err++;
      $display("FAIL div_start_low: got %b want 0", pdm_clk_o);
    end
    wait_pdm_edge(1'b1, ok);
    n = 0;
    while (pdm_clk_o === 1'b1 && n < 64) begin tick(); n++; end
    hi_len = n;
    while (pdm_clk_o === 1'b0 && n < 64) begin tick(); n++; end
    n_cmp++;
    if (hi_len != 4 || n != 8) begin
      n_err++;
      $display("FAIL div_period: got high %0d period %0d want high 4 period 8", hi_len, n);
    end
    for (int f = 0; f < 2; f++) begin
      wait_pdm_edge(1'b0, ok);
      wait_strobe(10, ok);
      n_cmp++;
      if (!ok || cic_data_o !== 1'b1) begin
        n_err++;
        $display("FAIL div_ch0 frame %0d: got valid %b data %b want 1 1", f, ok, cic_data_o);
      end
      tick();
      n_cmp++;
      if (cic_valid_o !== 1'b1 || cic_data_o !== 1'b0) begin
        n_err++;
        $display("FAIL div_ch1 frame %0d: got valid %b data %b want 1 0", f, cic_valid_o, cic_data_o);
      end
      tick();
      n_cmp++;
      if (cic_valid_o !== 1'b0) begin
        n_err++;
        $display("FAIL div_burst_end frame %0d: got valid %b want 0", f, cic_valid_o);
      end
    end
  endtask

  task automatic test_four_channels();
    bit ok;
    logic [3:0] exp_bits;
    exp_bits = 4'b1100;
    hi_bits  = 2'b10;
    lo_bits  = 2'b10;
    start_session(2'd3, 8'd3, 0);
    cfg_ch_num_i = 2'd0;
    tick();
    n_cmp++;
    if (cic_ch_num_o !== 2'd3 || cic_en_o !== 1'b1) begin
      n_err++;
      $display("FAIL ch4_cfg_latch: got ch %0d en %b want 3 1", cic_ch_num_o, cic_en_o);
    end
    for (int f = 0; f < 2; f++) begin
      wait_pdm_edge(1'b0, ok);
      wait_strobe(10, ok);
      n_cmp++;
      if (!ok) begin
        n_err++;
        $display("FAIL ch4_timeout frame %0d: got no strobe want strobe", f);
      end
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (cic_valid_o !== 1'b1 || cic_data_o !== exp_bits[k]) begin
          n_err++;
          $display("FAIL ch4_data frame %0d ch %0d: got valid %b data %b want 1 %b",
                   f, k, cic_valid_o, cic_data_o, exp_bits[k]);
        end
        tick();
      end
      n_cmp++;
      if (cic_valid_o !== 1'b0) begin
        n_err++;
        $display("FAIL ch4_idle frame %0d: got valid %b want 0", f, cic_valid_o);
      end
    end
  endtask

  task automatic test_pcm_capture();
    bit ok;
    pcm_tab[0]  = 16'h1234;
    pcm_tab[1]  = 16'hABCD;
    pcm_ready_i = 1'b1;
    start_session(2'd1, 8'd3, 2);
    wait_pcm(60, ok);
    n_cmp++;
    if (!ok || pcm_data_o !== 16'h1234 || pcm_ch_o !== 2'd0) begin
      n_err++;
      $display("FAIL pcm_first: got valid %b ch %0d data %h want 1 0 1234", ok, pcm_ch_o, pcm_data_o);
    end
    tick();
    n_cmp++;
    if (pcm_valid_o !== 1'b1 || pcm_data_o !== 16'hABCD || pcm_ch_o !== 2'd1) begin
      n_err++;
      $display("FAIL pcm_second: got valid %b ch %0d data %h want 1 1 abcd",
               pcm_valid_o, pcm_ch_o, pcm_data_o);
    end
    tick();
    n_cmp++;
    if (pcm_valid_o !== 1'b0 || overflow_o !== 1'b0) begin
      n_err++;
      $display("FAIL pcm_drained: got valid %b ovf %b want 0 0", pcm_valid_o, overflow_o);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) pcm_tab[i] = 16'h0100 + 16'(i);
    pcm_ready_i = 1'b0;
    start_session(2'd1, 8'd3, 6);
    for (int i = 0; i < 60; i++) tick();
    n_cmp++;
    if (pcm_valid_o !== 1'b1 || overflow_o !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_flag: got valid %b ovf %b want 1 1", pcm_valid_o, overflow_o);
    end
`ifdef PDM_CIC_CTRL_DROP_CNT_EN
    n_cmp++;
    if (drop_cnt_o !== 8'd2) begin
      n_err++;
      $display("FAIL ovf_drop_cnt: got %0d want 2", drop_cnt_o);
    end
`endif
    pcm_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (pcm_valid_o !== 1'b1 || pcm_data_o !== pcm_tab[k]) begin
        n_err++;
        $display("FAIL ovf_entry %0d: got valid %b data %h want 1 %h", k, pcm_valid_o, pcm_data_o, pcm_tab[k]);
      end
      tick();
    end
    n_cmp++;
    if (pcm_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_occupancy: got valid %b after 4 pops want 0", pcm_valid_o);
    end
    pcm_ready_i = 1'b0;
  endtask

  task automatic test_full_push_pop();
    int strobes;
    for (int i = 0; i < 8; i++) pcm_tab[i] = 16'h0200 + 16'(i);
    pcm_ready_i = 1'b0;
    start_session(2'd0, 8'd3, 5);
    strobes = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (cic_valid_o === 1'b1) strobes++;
      if (strobes == 5) break;
    end
    n_cmp++;
    if (strobes != 5 || pcm_data_o !== pcm_tab[0]) begin
      n_err++;
      $display("FAIL full_setup: got strobes %0d head %h want 5 %h", strobes, pcm_data_o, pcm_tab[0]);
    end
    pcm_ready_i = 1'b1;
    tick();
    pcm_ready_i = 1'b0;
    tick();
    n_cmp++;
    if (overflow_o !== 1'b0) begin
      n_err++;
      $display("FAIL full_no_drop: got ovf %b want 0", overflow_o);
    end
    pcm_ready_i = 1'b1;
    for (int k = 1; k < 5; k++) begin
      n_cmp++;
      if (pcm_valid_o !== 1'b1 || pcm_data_o !== pcm_tab[k]) begin
        n_err++;
        $display("FAIL full_entry %0d: got valid %b data %h want 1 %h", k, pcm_valid_o, pcm_data_o, pcm_tab[k]);
      end
      tick();
    end
    n_cmp++;
    if (pcm_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL full_occupancy: got valid %b after 4 pops want 0", pcm_valid_o);
    end
    pcm_ready_i = 1'b0;
  endtask

  task automatic test_disable_reenable();
    bit ok;
    for (int i = 0; i < 8; i++) pcm_tab[i] = 16'h0300 + 16'(i);
    hi_bits     = 2'b01;
    lo_bits     = 2'b00;
    pcm_ready_i = 1'b0;
    start_session(2'd3, 8'd3, 100);
    for (int i = 0; i < 40; i++) tick();
    n_cmp++;
    if (overflow_o !== 1'b1 || pcm_valid_o !== 1'b1) begin
      n_err++;
      $display("FAIL dis_setup: got ovf %b valid %b want 1 1", overflow_o, pcm_valid_o);
    end
    for (int i = 0; i < 16 && cic_valid_o === 1'b1; i++) tick();
    wait_strobe(20, ok);
    tick();
    n_cmp++;
    if (!ok || cic_valid_o !== 1'b1) begin
      n_err++;
      $display("FAIL dis_mid_burst: got found %b valid %b want 1 1", ok, cic_valid_o);
    end
    cfg_en_i = 1'b0;
    tick();
    n_cmp++;
    if ({cic_valid_o, pdm_clk_o, pcm_valid_o, overflow_o, cic_en_o} !== 5'd0) begin
      n_err++;
      $display("FAIL dis_cleared: got valid/pdm/pcm/ovf/en %b want 00000",
               {cic_valid_o, pdm_clk_o, pcm_valid_o, overflow_o, cic_en_o});
    end
    pcm_idx     = 0;
    model_left  = 1;
    pcm_tab[0]  = 16'h5A5A;
    pcm_ready_i = 1'b1;
    cfg_en_i    = 1'b1;
    tick();
    n_cmp++;
    if (pdm_clk_o !== 1'b0) begin
      n_err++;
      $display("FAIL reen_pdm_low: got %b want 0", pdm_clk_o);
    end
    wait_strobe(40, ok);
    n_cmp++;
    if (!ok || cic_data_o !== 1'b1) begin
      n_err++;
      $display("FAIL reen_first_data: got found %b data %b want 1 1", ok, cic_data_o);
    end
    wait_pcm(10, ok);
    n_cmp++;
    if (!ok || pcm_ch_o !== 2'd0 || pcm_data_o !== 16'h5A5A) begin
      n_err++;
      $display("FAIL reen_first_ch: got valid %b ch %0d data %h want 1 0 5a5a", ok, pcm_ch_o, pcm_data_o);
    end
  endtask

  initial begin
    rstn_i          = 1'b0;
    cfg_en_i        = 1'b0;
    cfg_ch_num_i    = 2'd0;
    cfg_clk_div_i   = 8'd3;
    pcm_ready_i     = 1'b0;
    cic_pcm_i       = 16'h0000;
    cic_pcm_valid_i = 1'b0;
    hi_bits         = 2'b00;
    lo_bits         = 2'b00;
    pcm_idx         = 0;
    model_left      = 0;
    for (int i = 0; i < 8; i++) pcm_tab[i] = 16'h0000;
    test_reset();
    test_divider_sampling();
    test_four_channels();
    test_pcm_capture();
    test_overflow();
    test_full_push_pop();
    test_disable_reenable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500000 want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pdm_cic_ctrl.md
Name: pdm_cic_ctrl

Overview:
Sequencer between PDM microphone pins and the shared multi-channel CIC decimator. Generates the PDM clock and samples up to two PDM lines on both clock phases, which gives up to 4 channels. Feeds one bit per channel to the CIC in strict channel order 0..N. Captures the decimated 16-bit PCM words into a small FIFO with a valid/ready output, tagged by channel.

Parameters:
- DIV_W, 8, width of the PDM clock divider config.
- FIFO_DEPTH, 4, PCM output FIFO depth in entries; power of 2, minimum 2.

Ports:
- clk_i  in  1  system clock.
- rstn_i  in  1  async reset, active-low.
- cfg_en_i  in  1  block enable; the rising edge starts a session.
- cfg_ch_num_i  in  2  active channels minus 1.
- cfg_clk_div_i  in  DIV_W  PDM half-period minus 1, in clk_i cycles; legal minimum 3.
- pdm_clk_o  out  1  PDM clock to the microphones.
- pdm_data_i  in  2  PDM data lines 0 and 1.
- cic_en_o  out  1  CIC enable.
- cic_ch_num_o  out  2  CIC channel count.
- cic_data_o  out  1  PDM bit for the current channel.
- cic_valid_o  out  1  one-cycle strobe per channel bit.
- cic_pcm_i  in  16  CIC output word.
- cic_pcm_valid_i  in  1  CIC output-phase flag.
- pcm_data_o  out  16  FIFO head data.
- pcm_ch_o  out  2  FIFO head channel.
- pcm_valid_o  out  1  FIFO not empty.
- pcm_ready_i  in  1  consumer accept.
- overflow_o  out  1  sticky flag: PCM word dropped or frame lost.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, FIFO empty, divider counter 0.
- Config latch:
  - cfg_ch_num_i and cfg_clk_div_i are latched on the cfg_en_i rising edge and ignored until the next session.
  - cic_en_o = cfg_en_i registered one cycle. cic_ch_num_o = latched ch_num.
- Divider:
  - Counter counts 0..div. At div it wraps to 0 and pdm_clk_o toggles.
  - PDM period = 2*(div+1) cycles. pdm_clk_o starts low in each session.
- Sampling:
  - On the toggle-to-high event, latch line0 into slot0 and line1 into slot2.
  - On the toggle-to-low event, latch line0 into slot1 and line1 into slot3.
  - Slot k is channel k.
- FSM states: IDLE, WAIT, FEED.
  - IDLE -> WAIT one cycle after cfg_en_i rises, once cic_en_o is high.
  - WAIT -> FEED on each toggle-to-low event, i.e. a complete frame.
  - FEED issues cic_valid_o for ch_num+1 consecutive cycles. cic_data_o = slot[idx], idx = 0..ch_num.
  - FEED -> WAIT after idx == ch_num.
  - If a frame completes while in FEED, which only happens with an illegal div: the new frame is dropped and overflow_o is set.
- PCM capture:
  - On a cycle after a cic_valid_o strobe for channel k during which cic_pcm_valid_i was high, push {k, cic_pcm_i} into the FIFO.
  - If the FIFO is full: drop the word and set overflow_o. Existing contents are unchanged.
- FIFO:
  - First-word-fall-through.
  - Pop when pcm_valid_o && pcm_ready_i.
  - Simultaneous push and pop when full is legal: the pop frees a slot and no drop occurs.
  - Push and pop in the same cycle when empty: the word appears the next cycle, no bypass.
- Disable mid-operation (cfg_en_i low):
  - Next cycle: FSM to IDLE, pdm_clk_o low, cic_valid_o low, divider cleared.
  - FIFO flushed, overflow_o cleared.
  - A FEED burst in progress is aborted; partial frames are discarded.
- Re-enable: a new session always starts with channel 0 and pdm_clk_o low.

Optional Feature:
PDM_CIC_CTRL_DROP_CNT_EN.
- Defined: adds output drop_cnt_o [7:0], a saturating count of dropped PCM words and lost frames. It saturates at 255 and is cleared with overflow_o.
- Undefined: port and counter are absent; overflow_o is unchanged.

Test Plan:
- div=3, ch_num=1, line0 bits alternating 1 on high phase / 0 on low phase -> pdm_clk_o period 8 cycles. After each falling toggle, 2 strobes: cic_data_o = 1 then 0.
- ch_num=3, line1 constant 1, line0 constant 0 -> strobe sequence per frame is data 0,0,1,1 on 4 consecutive cycles, then idle until the next frame.
- Model cic_pcm_valid_i high for one feed burst with cic_pcm_i = 0x1234 then 0xABCD, ch_num=1, ready=1 -> FIFO outputs (ch0, 0x1234) then (ch1, 0xABCD).
- pcm_ready_i=0, 6 PCM words pushed with FIFO_DEPTH=4 -> 4 entries held, overflow_o=1; with the macro, drop_cnt_o=2.
- Full FIFO with pcm_ready_i=1 on the same cycle as a push -> no drop, overflow_o stays 0, occupancy stays 4.
- Deassert cfg_en_i in the middle of a FEED burst (idx=1 of 3) -> next cycle cic_valid_o=0, pdm_clk_o=0, pcm_valid_o=0, overflow_o=0. Re-enable -> the first strobe is channel 0.
